// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 port arbiter and the pipeline stages
// that reach the DDR3 port through it.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    localparam logic [31:0] DDR3_BASE_ADDRESS = 32'h0400_0000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first pending requester at or after rr_ptr,
// wrapping around.
module rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    int               j;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate back to rr_ptr so the closest one wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        j             = 0;
        cand          = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = IDX_W'(j);
            if (pending_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 port between N_REQ requesters: latches pulsed requests, grants
// round-robin, runs one transaction at a time and returns completions to the owner.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ*ADDR_W-1:0]  req_address,
    input  logic [N_REQ-1:0]         req_rd_en,
    input  logic [N_REQ-1:0]         req_wr_en,
    input  logic [N_REQ*DATA_W-1:0]  req_write_data,
    output logic [DATA_W-1:0]        req_read_data,
    output logic [N_REQ-1:0]         req_read_complete,
    output logic [N_REQ-1:0]         req_write_complete,
    output logic [N_REQ-1:0]         req_error,
    output logic [ADDR_W-1:0]        sdram_address,
    output logic                     rd_en,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        write_data_input,
    input  logic [DATA_W-1:0]        read_data,
    input  logic                     write_complete,
    input  logic                     read_complete,
    output logic                     overflow_err,
    output logic                     timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    // The forced completion is decided one cycle early so its registered pulse
    // lands TIMEOUT_CYCLES cycles after ISSUE.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d, rr_q, rr_d, pick_idx;
    logic              pick_vld;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  pend_q, req_any, accept, drop, clr;
    logic              done_ok, done_to;
    mem_op_t           cur_op;
    mem_op_t           op_q    [N_REQ];
    logic [ADDR_W-1:0] addr_q  [N_REQ];
    logic [DATA_W-1:0] wdata_q [N_REQ];
    logic [DATA_W-1:0] rdata_q;
    logic [N_REQ-1:0]  rdc_q, wrc_q, err_q;
    logic              ovf_q, to_q;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(N_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .pending_i     (pend_q),
        .rr_ptr_i      (rr_q),
        .grant_valid_o (pick_vld),
        .grant_idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        done_ok = 1'b0;
        done_to = 1'b0;
        cur_op  = op_q[grant_q];
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if ((cur_op == OP_WRITE && write_complete) ||
                    (cur_op == OP_READ && read_complete)) begin
                    done_ok = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    done_to = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done_ok || done_to) begin
                    rr_d    = next_idx(grant_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A request for a requester whose pending flag clears this cycle is accepted.
    always_comb begin
        req_any = req_rd_en | req_wr_en;
        clr     = '0;
        accept  = '0;
        drop    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr[i]    = (done_ok || done_to) && (grant_q == IDX_W'(i));
            accept[i] = req_any[i] && (!pend_q[i] || clr[i]);
            drop[i]   = req_any[i] && pend_q[i] && !clr[i];
        end
    end

    always_comb begin
        sdram_address    = '0;
        write_data_input = '0;
        rd_en            = 1'b0;
        wr_en            = 1'b0;
        if (state_q == ISSUE) begin
            sdram_address    = addr_q[grant_q];
            write_data_input = wdata_q[grant_q];
            rd_en            = (op_q[grant_q] == OP_READ);
            wr_en            = (op_q[grant_q] == OP_WRITE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            rdata_q <= '0;
            rdc_q   <= '0;
            wrc_q   <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            pend_q  <= (pend_q & ~clr) | accept;
            ovf_q   <= ovf_q | (|drop);
            rdc_q   <= '0;
            wrc_q   <= '0;
            err_q   <= '0;
            if (done_ok || done_to) begin
                if (cur_op == OP_READ) begin
                    rdc_q[grant_q] <= 1'b1;
                    rdata_q        <= done_ok ? read_data : '0;
                end else begin
                    wrc_q[grant_q] <= 1'b1;
                end
                if (done_to) begin
                    err_q[grant_q] <= 1'b1;
                    to_q           <= 1'b1;
                end
            end
        end
    end

    // Request payload is only consumed behind a pending flag, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                op_q[i]    <= req_wr_en[i] ? OP_WRITE : OP_READ;
                addr_q[i]  <= req_address[i*ADDR_W +: ADDR_W];
                wdata_q[i] <= req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_read_data      = rdata_q;
    assign req_read_complete  = rdc_q;
    assign req_write_complete = wrc_q;
    assign req_error          = err_q;
    assign overflow_err       = ovf_q;
    assign timeout_err        = to_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: inputs change 1ns after a rising edge,
// outputs are checked at the same point against hand-computed values.
module tb_ddr3_port_arbiter;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int TO     = 16;

    logic                    clock = 1'b0;
    logic                    reset_n;
    logic [N_REQ*ADDR_W-1:0] req_address;
    logic [N_REQ-1:0]        req_rd_en, req_wr_en;
    logic [N_REQ*DATA_W-1:0] req_write_data;
    logic [DATA_W-1:0]       req_read_data;
    logic [N_REQ-1:0]        req_read_complete, req_write_complete, req_error;
    logic [ADDR_W-1:0]       sdram_address;
    logic                    rd_en, wr_en;
    logic [DATA_W-1:0]       write_data_input, read_data;
    logic                    write_complete, read_complete;
    logic                    overflow_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int pulses;

    localparam logic [31:0] A0 = 32'h0400_0000;
    localparam logic [31:0] A1 = 32'h0400_1000;

    ddr3_port_arbiter #(
        .N_REQ          (N_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .req_address        (req_address),
        .req_rd_en          (req_rd_en),
        .req_wr_en          (req_wr_en),
        .req_write_data     (req_write_data),
        .req_read_data      (req_read_data),
        .req_read_complete  (req_read_complete),
        .req_write_complete (req_write_complete),
        .req_error          (req_error),
        .sdram_address      (sdram_address),
        .rd_en              (rd_en),
        .wr_en              (wr_en),
        .write_data_input   (write_data_input),
        .read_data          (read_data),
        .write_complete     (write_complete),
        .read_complete      (read_complete),
        .overflow_err       (overflow_err),
        .timeout_err        (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        req_address    = '0;
        req_rd_en      = '0;
        req_wr_en      = '0;
        req_write_data = '0;
        read_data      = '0;
        write_complete = 1'b0;
        read_complete  = 1'b0;
        req_address[31:0]  = A0;
        req_address[63:32] = A1;
        tick();
        tick();
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_addr", sdram_address, 0);
        check("rst_rdata", req_read_data, 0);
        check("rst_cpl", {req_read_complete, req_write_complete, req_error}, 0);
        check("rst_errs", {overflow_err, timeout_err}, 0);
        reset_n = 1'b1;
        tick();

        // 1: single write from requester 0
        req_wr_en = 2'b01;
        req_write_data[127:0] = 128'h5A;
        tick();
        req_wr_en = 2'b00;
        check("t1_wr_T1", wr_en, 0);
        tick();
        check("t1_wr_T2", wr_en, 1);
        check("t1_rd_T2", rd_en, 0);
        check("t1_addr", sdram_address, A0);
        check("t1_data", write_data_input, 128'h5A);
        read_complete = 1'b1;           // wrong-type complete must be ignored
        tick();
        read_complete = 1'b0;
        check("t1_wr_once", wr_en, 0);
        check("t1_addr_idle", sdram_address, 0);
        tick();
        check("t1_ignore_rdc", {req_read_complete, req_write_complete}, 0);
        write_complete = 1'b1;
        tick();
        write_complete = 1'b0;
        check("t1_wrc", req_write_complete, 2'b01);
        check("t1_rdc", req_read_complete, 2'b00);
        tick();
        check("t1_wrc_pulse", req_write_complete, 2'b00);

        // 2: simultaneous reads, rr_ptr back at 0
        do_reset();
        req_rd_en = 2'b11;
        tick();
        req_rd_en = 2'b00;
        tick();
        check("t2_rd0", rd_en, 1);
        check("t2_addr0", sdram_address, A0);
        tick();
        check("t2_rd0_once", rd_en, 0);
        read_data = 128'h11;
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
        check("t2_rdc0", req_read_complete, 2'b01);
        check("t2_rdata0", req_read_data, 128'h11);
        check("t2_no_rd_overlap", rd_en, 0);
        tick();
        check("t2_rd1", rd_en, 1);
        check("t2_addr1", sdram_address, A1);
        check("t2_rdc_pulse", req_read_complete, 2'b00);
        tick();
        read_data = 128'h22;
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
        check("t2_rdc1", req_read_complete, 2'b10);
        check("t2_rdata1", req_read_data, 128'h22);
        read_data = 128'hDEAD;
        tick();
        check("t2_rdata_hold", req_read_data, 128'h22);

        // 3: requester 1 keeps re-requesting; requester 0 must still get a turn
        req_rd_en = 2'b10;
        tick();
        req_rd_en = 2'b00;
        tick();
        check("t3_g1_addr", sdram_address, A1);
        req_rd_en = 2'b01;
        tick();
        req_rd_en = 2'b10;              // re-request on the completion cycle
        read_data = 128'h33;
        read_complete = 1'b1;
        tick();
        req_rd_en = 2'b00;
        read_complete = 1'b0;
        check("t3_rdc1", req_read_complete, 2'b10);
        check("t3_rdata1", req_read_data, 128'h33);
        tick();
        check("t3_g0_rd", rd_en, 1);
        check("t3_g0_addr", sdram_address, A0);
        tick();
        read_data = 128'h44;
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
        check("t3_rdc0", req_read_complete, 2'b01);
        check("t3_rdata0", req_read_data, 128'h44);
        tick();
        check("t3_g1b_rd", rd_en, 1);
        check("t3_g1b_addr", sdram_address, A1);
        tick();
        read_data = 128'h55;
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
        check("t3_rdc1b", req_read_complete, 2'b10);
        check("t3_no_ovf", overflow_err, 0);

        // 4: second request while pending is dropped
        req_wr_en = 2'b01;
        req_write_data[127:0] = 128'h66;
        tick();
        req_write_data[127:0] = 128'h77;
        tick();
        req_wr_en = 2'b00;
        check("t4_wr", wr_en, 1);
        check("t4_data_first", write_data_input, 128'h66);
        check("t4_ovf", overflow_err, 1);
        tick();
        write_complete = 1'b1;
        tick();
        write_complete = 1'b0;
        check("t4_wrc", req_write_complete, 2'b01);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_en || rd_en) pulses++;
        end
        check("t4_one_txn", pulses, 0);

        // 5: watchdog
        req_rd_en = 2'b01;
        tick();
        req_rd_en = 2'b00;
        tick();                         // ISSUE cycle I
        check("t5_rd", rd_en, 1);
        req_rd_en = 2'b10;
        tick();                         // I+1
        req_rd_en = 2'b00;
        for (int i = 2; i < TO; i++) tick();
        check("t5_no_early_cpl", req_read_complete, 2'b00);
        check("t5_no_early_to", timeout_err, 0);
        tick();                         // I+16
        check("t5_rdc", req_read_complete, 2'b01);
        check("t5_err", req_error, 2'b01);
        check("t5_rdata0", req_read_data, 0);
        check("t5_to", timeout_err, 1);
        tick();
        check("t5_next_rd", rd_en, 1);
        check("t5_next_addr", sdram_address, A1);
        check("t5_err_pulse", req_error, 2'b00);

        // 6: reset in WAIT
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_to_clr", timeout_err, 0);
        check("t6_ovf_clr", overflow_err, 0);
        check("t6_outs", {rd_en, wr_en, sdram_address, req_read_complete, req_error}, 0);
        tick();
        reset_n = 1'b1;
        read_data = 128'h99;
        read_complete = 1'b1;
        tick();
        read_complete = 1'b0;
        check("t6_no_cpl", {req_read_complete, req_write_complete}, 0);
        check("t6_rdata", req_read_data, 0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_en || wr_en) pulses++;
        end
        check("t6_no_issue", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_port_arbiter.md
Name: ddr3_port_arbiter

Overview:
- Shares the single DDR3 access port (address, rd_en, wr_en, 128-bit write data, read data, write_complete, read_complete) between N_REQ pipeline stages, e.g. grayscale write-back and hysteresis readback.
- Each requester sees a replica of the DDR3 pulse/complete handshake.
- The arbiter latches pulsed requests, grants round-robin, issues one transaction at a time and routes completion and read data back to the owner.
- A watchdog releases the port if the memory side never completes.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 32, address width
DATA_W, 128, data width
TIMEOUT_CYCLES, 4096, WAIT-state cycles before forced release (>=2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_address  in  N_REQ*ADDR_W  per-requester address, slice i = requester i
req_rd_en  in  N_REQ  per-requester read request pulse
req_wr_en  in  N_REQ  per-requester write request pulse
req_write_data  in  N_REQ*DATA_W  per-requester write data
req_read_data  out  DATA_W  read data, valid with req_read_complete
req_read_complete  out  N_REQ  one-cycle read done to owner
req_write_complete  out  N_REQ  one-cycle write done to owner
req_error  out  N_REQ  one-cycle, coincident with a complete forced by timeout
sdram_address  out  ADDR_W  to DDR3 controller
rd_en  out  1  read pulse to DDR3
wr_en  out  1  write pulse to DDR3
write_data_input  out  DATA_W  to DDR3
read_data  in  DATA_W  from DDR3
write_complete  in  1  from DDR3
read_complete  in  1  from DDR3
overflow_err  out  1  sticky: request arrived while that requester was already pending
timeout_err  out  1  sticky: watchdog fired

Behaviour:
- One clock domain; reset is asynchronous and active-low (reset_n). Reset clears all outputs, the pending flags, the rr pointer and the counter to 0. The state machine goes to IDLE.
- Reset mid-transaction drops the transaction without completing it; the DDR3 side must be reset together with the arbiter.
- Request capture per requester i, on a cycle with req_rd_en[i] or req_wr_en[i]:
  - Registers pending[i], op[i] (write if wr_en, else read), address and data.
  - If rd_en and wr_en are both high, the write wins.
  - If pending[i] is already set, the request is dropped and overflow_err is set.
  - If pending[i] clears and a new request for i arrives in the same cycle, the new request is accepted (set wins).
- IDLE:
  - If any pending flag is set, grant the first pending index at or after rr_ptr, searching with wrap-around. Latch grant_idx and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive sdram_address and write_data_input from grant_idx, with rd_en or wr_en high for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
  - Outside ISSUE, sdram_address, write_data_input, rd_en and wr_en are all 0.
- WAIT:
  - A completion is the complete input that matches the op: write_complete for a write, read_complete for a read. A non-matching complete is ignored.
  - On completion:
    - Register read_data into req_read_data (reads only).
    - Pulse req_*_complete[grant_idx] for one cycle, on the next cycle.
    - Clear pending[grant_idx], set rr_ptr = grant_idx+1 mod N_REQ, and go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 without a completion:
    - Set timeout_err.
    - Pulse the complete and req_error to the owner, with req_read_data = 0.
    - Clear pending and advance rr_ptr as above, then go to IDLE.
- Latency:
  - Request pulse at cycle T sets pending at T+1.
  - With the port idle, rd_en/wr_en is issued at T+2.
  - A DDR3 complete at cycle C gives the requester complete at C+1.
- req_read_data holds its last value between reads.
- Sticky errors are cleared only by reset.

Decomposition:
- Package ddr3_arb_pkg:
  - arb_state_t {IDLE, ISSUE, WAIT}.
  - mem_op_t {OP_READ, OP_WRITE}.
  - DDR3_BASE_ADDRESS = 32'h04000000, shared with the pipeline stages.
- Sub-module rr_picker: combinational, inputs pending[N_REQ] and rr_ptr, outputs grant_valid and grant_idx.

Test Plan:
1. Requester 0 writes 0x5A to 0x04000000; DDR3 model completes after 3 cycles -> wr_en high for exactly one cycle at T+2 with the correct address and data; req_write_complete[0] pulses at C+1.
2. Requesters 0 and 1 pulse reads in the same cycle, rr_ptr=0 -> 0 is served first, then 1. rd_en pulses twice, never overlapping. Each complete goes only to its owner with its own read_data (0x11, then 0x22).
3. Requester 1 reads continuously while requester 0 issues one read -> after 1 completes, 0 is granted next (no starvation); pattern 1,0,1.
4. Second request from requester 0 while pending -> dropped, overflow_err=1, exactly one DDR3 transaction.
5. DDR3 never completes, TIMEOUT_CYCLES=16 -> timeout_err=1; req_read_complete[0] and req_error[0] pulse 16 cycles after ISSUE; req_read_data=0; the next pending request is then granted.
6. reset_n asserted in WAIT -> all outputs 0 immediately, pending cleared, no complete pulse after release.
